// File: rtl/dual_issue_dispatch_pkg.sv
// Shared types for the dual-issue dispatch stage: packed decoded-queue entry
// and default register numbers used by the hazard checks.
package dual_issue_dispatch_pkg;

  // Field order is MSB to LSB; the queue concatenates entries in this order.
  typedef struct packed {
    logic        ce;
    logic [31:0] pc;
    logic        jr;
    logic        jal;
    logic [15:0] imm;
    logic [5:0]  funct;
    logic [5:0]  opcode;
    logic        reg_dst;
    logic        alu_src;
    logic [31:0] data_rs;
    logic [31:0] data_rt;
    logic        memtoreg;
    logic        memwrite;
    logic [25:0] jal_addr;
    logic        regwrite;
    logic [4:0]  addr_rd;
    logic [4:0]  addr_rs;
    logic [4:0]  addr_rt;
    logic        force_pipe1;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // jal always links into this register.
  localparam logic [4:0] LINK_REG_DEF = 5'd31;
  // Writes to this register are discarded, so it never creates a hazard.
  localparam logic [4:0] ZERO_REG_DEF = 5'd0;

endpackage

// File: rtl/dual_issue_dispatch_if.sv
// Bundle of the queue-side and pipe-side signals of the dispatch stage.
//
// Handshake: di_o_q_re pops the queue head only while di_i_q_valid is high;
// the popped entry is the value present on di_i_q_entry at that posedge.
// An issued group (p0/p1 valids) is consumed on a posedge where di_i_ready
// is high; with di_i_ready low and any valid set, the group holds unchanged.
interface dual_issue_dispatch_if;
  import dual_issue_dispatch_pkg::*;

  logic               di_i_flush;
  logic               di_i_q_valid;
  logic [ENTRY_W-1:0] di_i_q_entry;
  logic               di_o_q_re;
  logic               di_i_ready;
  logic               di_o_p0_valid;
  logic [ENTRY_W-1:0] di_o_p0_entry;
  logic               di_o_p1_valid;
  logic [ENTRY_W-1:0] di_o_p1_entry;

  // Dispatch stage side.
  modport slave (
    input  di_i_flush, di_i_q_valid, di_i_q_entry, di_i_ready,
    output di_o_q_re, di_o_p0_valid, di_o_p0_entry, di_o_p1_valid, di_o_p1_entry
  );

  // Queue / execute-pipe side.
  modport master (
    output di_i_flush, di_i_q_valid, di_i_q_entry, di_i_ready,
    input  di_o_q_re, di_o_p0_valid, di_o_p0_entry, di_o_p1_valid, di_o_p1_entry
  );

endinterface

// File: rtl/dual_issue_dispatch_pair_check.sv
// Combinational pairing check between the older (a) and younger (b) entry
// of the issue window, plus destination-register decode.
module dispatch_pair_check
  import dual_issue_dispatch_pkg::*;
#(
  parameter logic [4:0] LINK_REG = LINK_REG_DEF,
  parameter logic [4:0] ZERO_REG = ZERO_REG_DEF
) (
  input  entry_t     a_i,
  input  entry_t     b_i,
  output logic       pairable_o,
  output logic       a_force_p1_o,
  output logic [4:0] a_dest_o,
  output logic [4:0] b_dest_o
);

  logic a_writes, b_writes;
  logic a_ctrl, b_ctrl, b_mem;
  logic raw_hz, waw_hz;

  // Only a handful of fields steer pairing; the rest ride along untouched.
  logic fields_unused;
  assign fields_unused = ^{a_i, b_i};

  // Destination decode: link register for jal, else rd/rt by reg_dst.
  always_comb begin
    a_dest_o = a_i.jal ? LINK_REG : (a_i.reg_dst ? a_i.addr_rd : a_i.addr_rt);
    b_dest_o = b_i.jal ? LINK_REG : (b_i.reg_dst ? b_i.addr_rd : b_i.addr_rt);
  end

  // Hazard and class terms feeding the pairing decision.
  always_comb begin
    a_writes   = (a_i.regwrite | a_i.jal) & (a_dest_o != ZERO_REG);
    b_writes   = (b_i.regwrite | b_i.jal) & (b_dest_o != ZERO_REG);
    a_ctrl     = a_i.jr | a_i.jal | a_i.force_pipe1;
    b_ctrl     = b_i.jr | b_i.jal | b_i.force_pipe1;
    b_mem      = b_i.memtoreg | b_i.memwrite;
    raw_hz     = a_writes & ((a_dest_o == b_i.addr_rs) | (a_dest_o == b_i.addr_rt));
    waw_hz     = a_writes & b_writes & (a_dest_o == b_dest_o);
    pairable_o = ~a_ctrl & ~b_ctrl & ~b_mem & ~raw_hz & ~waw_hz;
  end

  assign a_force_p1_o = a_i.force_pipe1;

endmodule

// File: rtl/dual_issue_dispatch.sv
// Dual-issue dispatch: pops the decoded queue into a two-slot window
// (A older, B younger) and issues a hazard-free pair or A alone into
// registered pipe-0 / pipe-1 ports.
module dual_issue_dispatch
  import dual_issue_dispatch_pkg::*;
#(
  parameter logic [4:0] LINK_REG = LINK_REG_DEF,
  parameter logic [4:0] ZERO_REG = ZERO_REG_DEF
) (
  input  logic                  qc_clk,
  input  logic                  qc_rst,
  dual_issue_dispatch_if.slave  di
);

  entry_t a_q, a_d, b_q, b_d;
  logic   a_v_q, a_v_d, b_v_q, b_v_d;
  entry_t p0_q, p0_d, p1_q, p1_d;
  logic   p0_v_q, p0_v_d, p1_v_q, p1_v_d;

  entry_t     q_entry;
  logic       adv, pairable, a_force_p1;
  logic       keep_a, keep_b, q_re;
  logic [4:0] a_dest, b_dest;

  assign q_entry = entry_t'(di.di_i_q_entry);

  dispatch_pair_check #(
    .LINK_REG (LINK_REG),
    .ZERO_REG (ZERO_REG)
  ) u_pair_check (
    .a_i          (a_q),
    .b_i          (b_q),
    .pairable_o   (pairable),
    .a_force_p1_o (a_force_p1),
    .a_dest_o     (a_dest),
    .b_dest_o     (b_dest)
  );

  // Destination decode is exposed by the checker for other consumers.
  logic dest_unused;
  assign dest_unused = ^{a_dest, b_dest};

  // Pipes stall together; an empty output stage always accepts a new group.
  assign adv = di.di_i_ready | (~p0_v_q & ~p1_v_q);

  // Issue selection, window compaction and refill into the lowest free slot.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    a_v_d  = a_v_q;
    b_v_d  = b_v_q;
    p0_d   = p0_q;
    p1_d   = p1_q;
    p0_v_d = p0_v_q;
    p1_v_d = p1_v_q;
    keep_a = a_v_q;
    keep_b = b_v_q;
    q_re   = 1'b0;
    if (di.di_i_flush) begin
      a_v_d  = 1'b0;
      b_v_d  = 1'b0;
      p0_v_d = 1'b0;
      p1_v_d = 1'b0;
    end else begin
      if (adv) begin
        p0_v_d = 1'b0;
        p1_v_d = 1'b0;
        if (a_v_q && b_v_q && pairable) begin
          p0_d   = a_q;
          p1_d   = b_q;
          p0_v_d = 1'b1;
          p1_v_d = 1'b1;
          keep_a = 1'b0;
          keep_b = 1'b0;
        end else if (a_v_q && (b_v_q || !di.di_i_q_valid)) begin
          // Lone issue; with B empty and the queue non-empty we instead
          // wait one cycle so A gets a chance to pair.
          if (a_force_p1) begin
            p1_d   = a_q;
            p1_v_d = 1'b1;
          end else begin
            p0_d   = a_q;
            p0_v_d = 1'b1;
          end
          a_d    = b_q;
          keep_a = b_v_q;
          keep_b = 1'b0;
        end
      end
      q_re  = qc_rst & di.di_i_q_valid & ~(keep_a & keep_b);
      a_v_d = keep_a;
      b_v_d = keep_b;
      if (q_re) begin
        if (!keep_a) begin
          a_d   = q_entry;
          a_v_d = 1'b1;
        end else begin
          b_d   = q_entry;
          b_v_d = 1'b1;
        end
      end
    end
  end

  // Window and issue registers with asynchronous active-low reset.
  always_ff @(posedge qc_clk or negedge qc_rst) begin
    if (!qc_rst) begin
      a_q    <= '0;
      b_q    <= '0;
      a_v_q  <= 1'b0;
      b_v_q  <= 1'b0;
      p0_q   <= '0;
      p1_q   <= '0;
      p0_v_q <= 1'b0;
      p1_v_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      a_v_q  <= a_v_d;
      b_v_q  <= b_v_d;
      p0_q   <= p0_d;
      p1_q   <= p1_d;
      p0_v_q <= p0_v_d;
      p1_v_q <= p1_v_d;
    end
  end

  assign di.di_o_q_re     = q_re;
  assign di.di_o_p0_valid = p0_v_q;
  assign di.di_o_p0_entry = p0_q;
  assign di.di_o_p1_valid = p1_v_q;
  assign di.di_o_p1_entry = p1_q;

endmodule

// File: tb/tb_dual_issue_dispatch.sv
// Bench for dual_issue_dispatch: a queue model feeds bursts, a greedy
// in-order pairing model predicts the issued groups, a monitor checks them.
module tb_dual_issue_dispatch;
  import dual_issue_dispatch_pkg::*;

  localparam int GW = 2 * ENTRY_W + 2;

  logic qc_clk, qc_rst;
  dual_issue_dispatch_if dif();

  dual_issue_dispatch dut (
    .qc_clk (qc_clk),
    .qc_rst (qc_rst),
    .di     (dif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  entry_t          src_q[$];
  entry_t          burst[$];
  logic [GW-1:0]   exp_q[$];
  bit              pop_pend, mon_en, flush_v;
  int              rdy_mode;
  int              pops, cyc, first_v;
  logic [GW-1:0]   snap;

  // ---------------- clock ----------------
  initial begin
    qc_clk = 1'b0;
    forever #5 qc_clk = ~qc_clk;
  end

  // ---------------- helpers ----------------
  task automatic check(string name, logic [GW-1:0] act, logic [GW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [GW-1:0] pack_grp(logic v0, logic [ENTRY_W-1:0] e0,
                                             logic v1, logic [ENTRY_W-1:0] e1);
    return {v0, v1, e0 & {ENTRY_W{v0}}, e1 & {ENTRY_W{v1}}};
  endfunction

  function automatic logic [GW-1:0] raw_out();
    return {dif.di_o_p0_valid, dif.di_o_p1_valid, dif.di_o_p0_entry, dif.di_o_p1_entry};
  endfunction

  function automatic entry_t mk(bit rw, bit rdst, int rd, int rs, int rt,
                                bit jal = 0, bit jr = 0, bit fp1 = 0,
                                bit mr = 0, bit mw = 0);
    entry_t e;
    e             = '0;
    e.ce          = 1'b1;
    e.pc          = $urandom;
    e.imm         = 16'($urandom);
    e.funct       = 6'($urandom);
    e.opcode      = 6'($urandom);
    e.alu_src     = ($urandom_range(0, 1) == 1);
    e.data_rs     = $urandom;
    e.data_rt     = $urandom;
    e.jal_addr    = 26'($urandom);
    e.regwrite    = rw;
    e.reg_dst     = rdst;
    e.addr_rd     = 5'(rd);
    e.addr_rs     = 5'(rs);
    e.addr_rt     = 5'(rt);
    e.jal         = jal;
    e.jr          = jr;
    e.force_pipe1 = fp1;
    e.memtoreg    = mr;
    e.memwrite    = mw;
    return e;
  endfunction

  function automatic entry_t mk_rand();
    return mk(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1),
              $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0));
  endfunction

  // ---------------- reference model ----------------
  function automatic int dest_of(entry_t e);
    if (e.jal) return 31;
    if (e.reg_dst) return int'(e.addr_rd);
    return int'(e.addr_rt);
  endfunction

  function automatic bit writes_of(entry_t e);
    return (e.regwrite || e.jal) && (dest_of(e) != 0);
  endfunction

  function automatic bit pairable_ref(entry_t a, entry_t b);
    if (a.jr || a.jal || a.force_pipe1) return 0;
    if (b.jr || b.jal || b.force_pipe1) return 0;
    if (b.memtoreg || b.memwrite) return 0;
    if (writes_of(a) && (dest_of(a) == int'(b.addr_rs) || dest_of(a) == int'(b.addr_rt))) return 0;
    if (writes_of(a) && writes_of(b) && dest_of(a) == dest_of(b)) return 0;
    return 1;
  endfunction

  // A burst presented back-to-back is issued greedily in program order:
  // pair the two oldest when legal, otherwise the oldest alone.
  task automatic issue_burst();
    int i;
    i = 0;
    while (i < burst.size()) begin
      if (i + 1 < burst.size() && pairable_ref(burst[i], burst[i+1])) begin
        exp_q.push_back(pack_grp(1'b1, burst[i], 1'b1, burst[i+1]));
        i += 2;
      end else begin
        if (burst[i].force_pipe1) exp_q.push_back(pack_grp(1'b0, '0, 1'b1, burst[i]));
        else                      exp_q.push_back(pack_grp(1'b1, burst[i], 1'b0, '0));
        i += 1;
      end
    end
    foreach (burst[k]) src_q.push_back(burst[k]);
    burst.delete();
  endtask

  // ---------------- driver ----------------
  // One clock: drive at negedge (queue head advances after a pop),
  // sample the pop request just before the posedge.
  task automatic cycle();
    @(negedge qc_clk);
    if (pop_pend && src_q.size() > 0) void'(src_q.pop_front());
    pop_pend          = 0;
    dif.di_i_flush    = flush_v;
    dif.di_i_q_valid  = (src_q.size() > 0);
    if (src_q.size() > 0) dif.di_i_q_entry = src_q[0];
    else                  dif.di_i_q_entry = '0;
    case (rdy_mode)
      0:       dif.di_i_ready = 1'b0;
      1:       dif.di_i_ready = 1'b1;
      default: dif.di_i_ready = ($urandom_range(0, 3) != 0);
    endcase
    #4;
    if (dif.di_o_q_re) begin
      pop_pend = 1;
      pops++;
    end
    cyc++;
    if (first_v == 0 && (dif.di_o_p0_valid || dif.di_o_p1_valid)) first_v = cyc;
  endtask

  task automatic drain(int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || src_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    check_int("drain_groups_left", exp_q.size() + src_q.size(), 0);
    repeat (3) cycle();
  endtask

  task automatic directed(string name, int exp_first, int exp_pops);
    rdy_mode = 1;
    pops     = 0;
    cyc      = 0;
    first_v  = 0;
    issue_burst();
    drain(60);
    if (exp_first > 0) check_int({name, "_latency"}, first_v, exp_first);
    check_int({name, "_pops"}, pops, exp_pops);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [GW-1:0] cur, hold_snap;
    bit            hold_pend;
    hold_pend = 0;
    hold_snap = '0;
    forever begin
      @(negedge qc_clk);
      #3;
      cur = pack_grp(dif.di_o_p0_valid, dif.di_o_p0_entry,
                     dif.di_o_p1_valid, dif.di_o_p1_entry);
      if (!mon_en) begin
        hold_pend = 0;
      end else begin
        if (hold_pend) check("stall_hold_group", cur, hold_snap);
        hold_pend = 0;
        if (dif.di_o_p0_valid || dif.di_o_p1_valid) begin
          if (dif.di_i_ready) begin
            if (exp_q.size() == 0) begin
              n_tests++;
              n_fail++;
              $display("FAIL unexpected_issue: got %h expected no group", cur);
            end else begin
              check("issue_group", cur, exp_q.pop_front());
            end
          end else begin
            hold_snap = cur;
            hold_pend = 1;
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    qc_rst            = 1'b0;
    flush_v           = 0;
    mon_en            = 1;
    rdy_mode          = 1;
    pop_pend          = 0;
    pops              = 0;
    cyc               = 0;
    first_v           = 0;
    dif.di_i_flush    = 1'b0;
    dif.di_i_q_valid  = 1'b1;
    dif.di_i_q_entry  = mk(1, 1, 3, 1, 2);
    dif.di_i_ready    = 1'b1;

    // Reset state, with a pending queue entry that must not be popped.
    #12;
    check_int("reset_q_re", int'(dif.di_o_q_re), 0);
    check("reset_outputs", raw_out(), '0);
    dif.di_i_q_valid = 1'b0;
    @(negedge qc_clk);
    #2 qc_rst = 1'b1;

    // Directed patterns.
    burst.push_back(mk(1, 1, 3, 1, 2));
    burst.push_back(mk(1, 1, 4, 5, 6));
    directed("indep_pair", 4, 2);

    burst.push_back(mk(1, 1, 3, 1, 2));
    burst.push_back(mk(1, 1, 4, 3, 6));
    directed("raw", 0, 2);

    burst.push_back(mk(1, 1, 0, 1, 2));
    burst.push_back(mk(1, 1, 4, 0, 0));
    directed("zero_reg", 4, 2);

    burst.push_back(mk(0, 0, 0, 1, 2, 1));
    burst.push_back(mk(1, 1, 5, 31, 2));
    directed("jal_link", 0, 2);

    burst.push_back(mk(0, 0, 0, 7, 0, 0, 1, 1));
    directed("jr_pipe1", 3, 1);

    burst.push_back(mk(1, 1, 3, 1, 2));
    burst.push_back(mk(1, 0, 0, 4, 8, 0, 0, 0, 1));
    directed("mem_b", 0, 2);

    // Randomised bursts with random back-pressure.
    rdy_mode = 2;
    repeat (12) begin
      int n;
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) burst.push_back(mk_rand());
      issue_burst();
      drain(400);
    end

    // Stall with a full window, then flush.
    mon_en   = 0;
    rdy_mode = 0;
    for (int i = 0; i < 6; i++) src_q.push_back(mk(1, 1, 10 + i, 20, 21));
    repeat (5) cycle();
    check_int("stall_pair_valid", int'(dif.di_o_p0_valid & dif.di_o_p1_valid), 1);
    snap = raw_out();
    repeat (3) begin
      cycle();
      check_int("stall_q_re", int'(dif.di_o_q_re), 0);
      check("stall_outputs", raw_out(), snap);
    end
    flush_v = 1;
    cycle();
    check_int("flush_q_re", int'(dif.di_o_q_re), 0);
    flush_v  = 0;
    src_q.delete();
    pop_pend = 0;
    cycle();
    check_int("flush_valids", int'({dif.di_o_p0_valid, dif.di_o_p1_valid}), 0);
    rdy_mode = 1;
    repeat (3) cycle();
    check_int("post_flush_idle", int'({dif.di_o_p0_valid, dif.di_o_p1_valid}), 0);
    mon_en = 1;

    // Asynchronous reset in the middle of a stream.
    rdy_mode = 2;
    for (int i = 0; i < 8; i++) burst.push_back(mk_rand());
    issue_burst();
    repeat (4) cycle();
    mon_en = 0;
    #3 qc_rst = 1'b0;
    #1;
    check("async_reset_outputs", raw_out(), '0);
    check_int("async_reset_q_re", int'(dif.di_o_q_re), 0);
    exp_q.delete();
    src_q.delete();
    pop_pend = 0;
    repeat (2) cycle();
    #2 qc_rst = 1'b1;
    repeat (2) cycle();
    mon_en = 1;

    burst.push_back(mk(1, 1, 7, 1, 2));
    burst.push_back(mk(1, 1, 8, 5, 6));
    directed("after_reset_pair", 4, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
